// File: rtl/spi_burst_ram_pkg.sv
// Shared definitions for the SPI burst RAM slave.
//   - 2-bit opcodes carried on the first two MOSI bits of a frame
//   - frame state machine encoding
package spi_burst_ram_pkg;

    localparam logic [1:0] OP_SET_WADDR = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_SET_RADDR = 2'b10;
    localparam logic [1:0] OP_READ      = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        HOLD,
        WRITE,
        READ
    } state_e;

endpackage

// File: rtl/spi_burst_ram_mem.sv
// Single-port-style word memory with one synchronous write port and one
// synchronous, registered read port. Contents are never reset.
// Ports:
//   clk_i    : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address, sampled every edge
//   rdata_o  : registered read data (mem[raddr_i] from the previous edge)
module spi_burst_ram_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/spi_burst_ram_slave.sv
// SPI slave with integrated word RAM and auto-incrementing write/read
// pointers. clk is the bit clock; one MOSI bit is sampled and one MISO bit
// is presented per rising edge while ss_n is low. A frame starts with a
// 2-bit opcode, followed by an address (SET_WADDR/SET_RADDR), a stream of
// write words (WRITE) or a turnaround bit and a stream of read words (READ).
// Ports:
//   clk   : bit clock, rising edge
//   rst_n : asynchronous active-low reset
//   MOSI  : serial data in, MSB first
//   MISO  : serial data out, MSB first, registered; 0 outside READ output
//   ss_n  : active-low select, high ends the frame
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no frame; first low-ss_n edge captures opcode MSB
// CMD   | second opcode bit, decode
// ADDR  | shifting in address for SET_WADDR / SET_RADDR
// HOLD  | address committed, ignore MOSI until ss_n rises
// WRITE | shifting in words, commit each full word at wptr
// READ  | turnaround then continuous word shift-out from rptr
module spi_burst_ram_slave
    import spi_burst_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    output logic MISO,
    input  logic ss_n
);

    localparam int SH_W  = ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) - 1;
    localparam int CNT_W = $clog2(SH_W + 1);

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]      WORD_LAST = CNT_W'(DATA_WIDTH - 1);

    state_e                state_q;
    logic [1:0]            op_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [SH_W-1:0]       sh_q;
    logic [DATA_WIDTH-1:0] so_q;
    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [ADDR_WIDTH-1:0] rptr_q;
    logic                  miso_q;

    logic [ADDR_WIDTH-1:0] addr_shift;
    logic [ADDR_WIDTH-1:0] addr_load;
    logic [DATA_WIDTH-1:0] word_shift;
    logic [ADDR_WIDTH-1:0] wptr_inc;
    logic [ADDR_WIDTH-1:0] rptr_inc;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // The shift register holds only the bits before the current one; the
    // completed address/word is formed with the live MOSI bit so it can be
    // committed on the very edge that samples its last bit.
    always_comb begin
        addr_shift = {sh_q[ADDR_WIDTH-2:0], MOSI};
        word_shift = {sh_q[DATA_WIDTH-2:0], MOSI};
        addr_load  = ({1'b0, addr_shift} >= DEPTH_EXT) ? '0 : addr_shift;
        wptr_inc   = (wptr_q == LAST_ADDR) ? '0 : wptr_q + ADDR_WIDTH'(1);
        rptr_inc   = (rptr_q == LAST_ADDR) ? '0 : rptr_q + ADDR_WIDTH'(1);
        mem_we     = (state_q == WRITE) && !ss_n && (cnt_q == WORD_LAST);
    end

    // Read port tracks rptr every edge, so mem[rptr] is already registered
    // when READ needs it (turnaround edge, and one edge after each increment).
    spi_burst_ram_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wptr_q),
        .wdata_i (word_shift),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_SET_WADDR;
            cnt_q   <= '0;
            sh_q    <= '0;
            so_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            miso_q  <= 1'b0;
        end else if (ss_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            miso_q  <= 1'b0;
        end else begin
            miso_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sh_q    <= SH_W'(MOSI);
                    state_q <= CMD;
                end
                CMD: begin
                    op_q  <= {sh_q[0], MOSI};
                    cnt_q <= '0;
                    sh_q  <= '0;
                    case ({sh_q[0], MOSI})
                        OP_WRITE: state_q <= WRITE;
                        OP_READ:  state_q <= READ;
                        default:  state_q <= ADDR;
                    endcase
                end
                ADDR: begin
                    sh_q <= (sh_q << 1) | SH_W'(MOSI);
                    if (cnt_q == ADDR_LAST) begin
                        if (op_q == OP_SET_RADDR) begin
                            rptr_q <= addr_load;
                        end else begin
                            wptr_q <= addr_load;
                        end
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    state_q <= HOLD;
                end
                WRITE: begin
                    sh_q <= (sh_q << 1) | SH_W'(MOSI);
                    if (cnt_q == WORD_LAST) begin
                        cnt_q  <= '0;
                        wptr_q <= wptr_inc;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                READ: begin
                    if (cnt_q == '0) begin
                        so_q   <= mem_rdata << 1;
                        miso_q <= mem_rdata[DATA_WIDTH-1];
                        rptr_q <= rptr_inc;
                        cnt_q  <= CNT_W'(1);
                    end else begin
                        so_q   <= so_q << 1;
                        miso_q <= so_q[DATA_WIDTH-1];
                        cnt_q  <= (cnt_q == WORD_LAST) ? '0 : cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MISO = miso_q;

endmodule
